// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: bus widths, MW bus field
// offsets, the packed MW bus layout and the exception code constants.
package wb_stage_pkg;

    localparam int MW_BUS_W = 191;
    localparam int WD_FOR_W = 52;

    // MW bus field offsets (MSB / LSB)
    localparam int MW_PC_MSB        = 190;
    localparam int MW_PC_LSB        = 159;
    localparam int MW_RESULT_MSB    = 158;
    localparam int MW_RESULT_LSB    = 127;
    localparam int MW_GR_WE_BIT     = 126;
    localparam int MW_DEST_MSB      = 125;
    localparam int MW_DEST_LSB      = 121;
    localparam int MW_VADDR_MSB     = 120;
    localparam int MW_VADDR_LSB     = 89;
    localparam int MW_EX_BIT        = 88;
    localparam int MW_ECODE_MSB     = 87;
    localparam int MW_ECODE_LSB     = 80;
    localparam int MW_ESUBCODE_BIT  = 79;
    localparam int MW_CSR_ADDR_MSB  = 78;
    localparam int MW_CSR_ADDR_LSB  = 65;
    localparam int MW_CSR_WE_BIT    = 64;
    localparam int MW_CSR_WMASK_MSB = 63;
    localparam int MW_CSR_WMASK_LSB = 32;
    localparam int MW_CSR_WDATA_MSB = 31;
    localparam int MW_CSR_WDATA_LSB = 0;

    // Exception codes
    localparam logic [7:0] ECODE_INT = 8'h00;
    localparam logic [7:0] ECODE_ADE = 8'h08;
    localparam logic [7:0] ECODE_ALE = 8'h09;
    localparam logic [7:0] ECODE_SYS = 8'h0B;
    localparam logic [7:0] ECODE_BRK = 8'h0C;
    localparam logic [7:0] ECODE_INE = 8'h0D;

    // Packed view of the MW bus; field order matches the offsets above
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] vaddr;
        logic        ex;
        logic [7:0]  ecode;
        logic        esubcode;
        logic [13:0] csr_addr;
        logic        csr_we;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wdata;
    } mw_bus_t;

endpackage

// File: rtl/wb_stage_if.sv
// Memory-to-writeback handshake: MW_valid/MW_BUS from the memory stage,
// W_allowin back from writeback.
interface wb_stage_if;
    import wb_stage_pkg::*;

    // Handshake: a transfer happens on a rising edge where MW_valid and
    // W_allowin are both 1; MW_BUS is only meaningful while MW_valid is 1.
    logic                MW_valid;
    logic [MW_BUS_W-1:0] MW_BUS;
    logic                W_allowin;

    modport master (output MW_valid, output MW_BUS, input W_allowin);
    modport slave  (input MW_valid, input MW_BUS, output W_allowin);

endinterface

// File: rtl/wb_retire_cnt.sv
// Retired-instruction counter: free-running enable counter with a
// synchronous active-low clear; wraps naturally at all-ones.
module wb_retire_cnt #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    // Count one per enabled edge, clear on reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: holds one instruction from the memory stage for one
// cycle, drives the register-file and CSR write ports, raises the
// exception commit pulse and counts retired instructions.
// Optional feature macro: WB_DEBUG_TRACE_EN adds the debug_wb_* trace ports.
module wb_stage #(
    parameter int MW_BUS_W = wb_stage_pkg::MW_BUS_W,
    parameter int WD_FOR_W = wb_stage_pkg::WD_FOR_W
) (
    input  logic                clk,
    input  logic                rstn,
    wb_stage_if.slave           mw,
    output logic                rf_we,
    output logic [4:0]          rf_waddr,
    output logic [31:0]         rf_wdata,
    output logic                csr_we,
    output logic [13:0]         csr_addr,
    output logic [31:0]         csr_wmask,
    output logic [31:0]         csr_wdata,
    output logic                ex_en,
    output logic [7:0]          ex_ecode,
    output logic                ex_esubcode,
    output logic [31:0]         ex_pc,
    output logic [31:0]         ex_vaddr,
    output logic [WD_FOR_W-1:0] WD_for_BUS,
    output logic [63:0]         instret
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [31:0]         debug_wb_pc,
    output logic [3:0]          debug_wb_rf_we,
    output logic [4:0]          debug_wb_rf_wnum,
    output logic [31:0]         debug_wb_rf_wdata
`endif
);

    import wb_stage_pkg::*;

    logic                w_valid;
    logic                w_ready_go;
    logic [MW_BUS_W-1:0] bus_q;
    mw_bus_t             wb;
    logic                retire;

    // Writeback always completes in one cycle, so the stage can always
    // take a new instruction.
    assign w_ready_go   = 1'b1;
    assign mw.W_allowin = !w_valid || w_ready_go;

    // Stage valid: an exception commit flushes whatever is arriving
    always_ff @(posedge clk) begin
        if (!rstn) begin
            w_valid <= 1'b0;
        end else if (mw.W_allowin) begin
            w_valid <= mw.MW_valid && !ex_en;
        end
    end

    // Bus register: latch only instructions that are actually accepted
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bus_q <= '0;
        end else if (mw.MW_valid && mw.W_allowin && !ex_en) begin
            bus_q <= mw.MW_BUS;
        end
    end

    assign wb = bus_q;

    // Register-file write port; r0 writes are left for the regfile to drop
    assign rf_we    = w_valid && wb.gr_we && !wb.ex;
    assign rf_waddr = wb.dest;
    assign rf_wdata = wb.result;

    // CSR write port
    assign csr_we    = w_valid && wb.csr_we && !wb.ex;
    assign csr_addr  = wb.csr_addr;
    assign csr_wmask = wb.csr_wmask;
    assign csr_wdata = wb.csr_wdata;

    // Exception commit: info is zeroed whenever no exception is committing
    assign ex_en       = w_valid && wb.ex;
    assign ex_ecode    = ex_en ? wb.ecode    : 8'h00;
    assign ex_esubcode = ex_en ? wb.esubcode : 1'b0;
    assign ex_pc       = ex_en ? wb.pc       : 32'h0;
    assign ex_vaddr    = ex_en ? wb.vaddr    : 32'h0;

    // Forward to decode for hazard detection, same cycle as the writes
    assign WD_for_BUS = {rf_waddr & {5{rf_we}}, rf_wdata, csr_we, csr_addr};

    // An instruction retires on the edge that ends its writeback cycle
    assign retire = w_valid && !wb.ex;

    wb_retire_cnt #(.W(64)) u_retire_cnt (
        .clk  (clk),
        .rstn (rstn),
        .en   (retire),
        .cnt  (instret)
    );

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc       = wb.pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter MW_BUS_W, default 191: MW bus width, fixed by the shared package.
REQ-002 Parameter WD_FOR_W, default 52: writeback-to-decode forward bus width.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rstn  in  1  reset, synchronous, active-low.
REQ-005 MW_valid  in  1  memory stage offers an instruction.
REQ-006 MW_BUS  in  191  {pc[190:159], result[158:127], gr_we[126], dest[125:121], vaddr[120:89], ex[88], ecode[87:80], esubcode[79], csr_addr[78:65], csr_we[64], csr_wmask[63:32], csr_wdata[31:0]}.
REQ-007 W_allowin  out  1  stage accepts MW_BUS this cycle.
REQ-008 rf_we / rf_waddr / rf_wdata  out  1/5/32  register file write port.
REQ-009 csr_we / csr_addr / csr_wmask / csr_wdata  out  1/14/32/32  CSR write port.
REQ-010 ex_en  out  1  exception commit pulse, broadcast to all stages as flush.
REQ-011 ex_ecode / ex_esubcode / ex_pc / ex_vaddr  out  8/1/32/32  exception info for the CSR unit.
REQ-012 WD_for_BUS  out  52  {dest masked by rf_we [51:47], result [46:15], csr_we [14], csr_addr [13:0]}.
REQ-013 instret  out  64  retired-instruction count.

Function
REQ-014 W_ready_go is 1; W_allowin = !W_valid || W_ready_go.
REQ-015 When W_allowin, W_valid <= MW_valid && !ex_en; MW_BUS latched into the bus register when MW_valid && W_allowin && !ex_en.
REQ-016 rf_we = W_valid && gr_we && !ex; rf_waddr = dest; rf_wdata = result; write to r0 still asserted (regfile ignores it).
REQ-017 csr_we = W_valid && csr_we_field && !ex; addr/mask/data pass through from the latched bus.
REQ-018 ex_en = W_valid && ex, combinational; ex_* outputs driven from the latched bus, all-zero when ex_en is 0.
REQ-019 ex_en lasts exactly one cycle: the excepting instruction's W_valid clears on the next edge.
REQ-020 Same-cycle ex_en and MW_valid: incoming instruction discarded; W_valid is 0 next cycle.
REQ-021 instret += 1 on each edge where W_valid && !ex; 64-bit wrap from all-ones to 0; no increment on exception or bubble.
REQ-022 WD_for_BUS dest field = dest & {5{rf_we}}, csr_we field = csr_we output; zero latency relative to the writes.
REQ-023 Latency: an instruction accepted at edge N performs its writes during cycle N..N+1 and retires at edge N+1.

Reset
REQ-024 On rstn=0 at an edge: W_valid=0, bus register=0, instret=0; hence rf_we=csr_we=ex_en=0 and WD_for_BUS=0 in the following cycle.
REQ-025 Reset asserted mid-operation drops the held instruction without any write or ex_en.

Configuration
REQ-026 Macro WB_DEBUG_TRACE_EN: when defined, add outputs debug_wb_pc[31:0], debug_wb_rf_we[3:0] = {4{rf_we}}, debug_wb_rf_wnum[4:0], debug_wb_rf_wdata[31:0].
REQ-027 Without WB_DEBUG_TRACE_EN those ports do not exist; all other behaviour is unchanged.

Structure
REQ-028 Shared package/header holds MW_BUS_W, WD_FOR_W, MW field bit offsets, and ecode constants.
REQ-029 Sub-module wb_retire_cnt (64-bit enable counter with sync reset) implements instret.

Verification
REQ-030 Load pc=0x1c000000, result=0x12345678, gr_we=1, dest=5, ex=0 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345678, instret 0->1.
REQ-031 ex=1, ecode=0x08, pc=0x1c000010, gr_we=1, csr_we=1 -> ex_en=1 for one cycle, rf_we=0, csr_we=0, ex_pc=0x1c000010, instret unchanged.
REQ-032 Exception held while MW_valid=1 offers the next instruction -> next instruction dropped, W_valid=0, no writes.
REQ-033 csr_we=1, csr_addr=0x0006, mask=0xFFFFFFFF, data=0xA5 -> csr_we=1, WD_for_BUS[14]=1, [13:0]=0x0006.
REQ-034 Force instret=0xFFFFFFFF_FFFFFFFF, retire one instruction -> instret=0.
REQ-035 rstn=0 for one edge while a valid gr_we instruction is held -> rf_we=0 next cycle, instret=0.
